// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, read-mode enum and depth helper for sync_fifo_param
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_THRESH = fifo_depth(DEF_ADDR_W) - 2;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  // Storage is deliberately not reset; stale words are never observable as valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO, STD/FWFT read; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = fifo_depth(ADDR_W) - 2,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_cnt
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int               DEPTH     = fifo_depth(ADDR_W);
  localparam fifo_mode_e       MODE      = fifo_mode_e'(FWFT != 0);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  AF_CNT    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0]  AE_CNT    = (ADDR_W + 1)'(AE_THRESH);
  localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W + 1)'(1);

  if (AE_THRESH >= AF_THRESH) begin : g_chk_thresh_order
    $error("sync_fifo_param: AE_THRESH must be below AF_THRESH");
  end
  if (AF_THRESH > DEPTH) begin : g_chk_af_range
    $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_acc, wr_acc;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Flags decode only the registered count, so wr/rd never reach them combinationally.
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_CNT);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
  assign fifo_cnt     = cnt_q;
  assign data_out     = (MODE == FIFO_FWFT) ? mem_rdata : dout_q;

  always_comb begin
    rd_acc   = rd & ~empty;
    wr_acc   = wr & (~full | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (MODE == FIFO_STD && rd_acc) begin
      dout_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr & full & ~rd_acc) ovf_q <= 1'b1;
      if (rd & empty)          udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - queue-model scoreboard bench for sync_fifo_param (STD, FWFT, 16x4); honours FIFO_ERR_FLAGS_EN
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr  = 1'b0;
  logic        rd  = 1'b0;
  logic [15:0] din = '0;

  logic [7:0]  s_dout, f_dout;
  logic [15:0] w_dout;
  logic        s_full, s_empty, s_af, s_ae;
  logic        f_full, f_empty, f_af, f_ae;
  logic        w_full, w_empty, w_af, w_ae;
  logic [3:0]  s_cnt, f_cnt;
  logic [2:0]  w_cnt;
`ifdef FIFO_ERR_FLAGS_EN
  logic        s_ovf, s_udf, f_ovf, f_udf, w_ovf, w_udf;
`endif

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .data_in(din[7:0]), .rd(rd), .data_out(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .fifo_cnt(s_cnt)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(s_ovf), .underflow(s_udf)
`endif
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .data_in(din[7:0]), .rd(rd), .data_out(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .fifo_cnt(f_cnt)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(f_ovf), .underflow(f_udf)
`endif
  );

  sync_fifo_param #(.DATA_W(16), .ADDR_W(2), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) u_w16 (
    .clk(clk), .rst(rst), .wr(wr), .data_in(din), .rd(rd), .data_out(w_dout),
    .full(w_full), .empty(w_empty), .almost_full(w_af), .almost_empty(w_ae), .fifo_cnt(w_cnt)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(w_ovf), .underflow(w_udf)
`endif
  );

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  // Reference model: plain queues of stored words plus scoreboards of expected reads.
  logic [7:0]  q8[$];
  logic [15:0] q4[$];
  logic [7:0]  exp_std[$];
  logic [7:0]  exp_fw[$];
  logic [15:0] exp_w[$];
  logic [7:0]  hold8  = '0;
  logic [15:0] hold16 = '0;
  bit          ovf8 = 0, udf8 = 0, ovf4 = 0, udf4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n8 = q8.size();
    int n4 = q4.size();
    check("s_cnt",   32'(s_cnt),   n8);
    check("s_full",  32'(s_full),  32'(n8 == 8));
    check("s_empty", 32'(s_empty), 32'(n8 == 0));
    check("s_af",    32'(s_af),    32'(n8 >= 6));
    check("s_ae",    32'(s_ae),    32'(n8 <= 2));
    check("s_hold",  32'(s_dout),  32'(hold8));
    check("f_cnt",   32'(f_cnt),   n8);
    check("f_full",  32'(f_full),  32'(n8 == 8));
    check("f_empty", 32'(f_empty), 32'(n8 == 0));
    check("f_af",    32'(f_af),    32'(n8 >= 6));
    check("f_ae",    32'(f_ae),    32'(n8 <= 2));
    check("w_cnt",   32'(w_cnt),   n4);
    check("w_full",  32'(w_full),  32'(n4 == 4));
    check("w_empty", 32'(w_empty), 32'(n4 == 0));
    check("w_af",    32'(w_af),    32'(n4 >= 3));
    check("w_ae",    32'(w_ae),    32'(n4 <= 2));
    check("w_hold",  32'(w_dout),  32'(hold16));
`ifdef FIFO_ERR_FLAGS_EN
    check("s_ovf", 32'(s_ovf), 32'(ovf8));
    check("s_udf", 32'(s_udf), 32'(udf8));
    check("f_ovf", 32'(f_ovf), 32'(ovf8));
    check("f_udf", 32'(f_udf), 32'(udf8));
    check("w_ovf", 32'(w_ovf), 32'(ovf4));
    check("w_udf", 32'(w_udf), 32'(udf4));
`endif
  endtask

  task automatic check_reset();
    check("rst_s_cnt",   32'(s_cnt),   0);
    check("rst_s_empty", 32'(s_empty), 1);
    check("rst_s_ae",    32'(s_ae),    1);
    check("rst_s_full",  32'(s_full),  0);
    check("rst_s_af",    32'(s_af),    0);
    check("rst_s_dout",  32'(s_dout),  0);
    check("rst_f_cnt",   32'(f_cnt),   0);
    check("rst_f_empty", 32'(f_empty), 1);
    check("rst_w_cnt",   32'(w_cnt),   0);
    check("rst_w_empty", 32'(w_empty), 1);
    check("rst_w_ae",    32'(w_ae),    1);
    check("rst_w_full",  32'(w_full),  0);
    check("rst_w_af",    32'(w_af),    0);
    check("rst_w_dout",  32'(w_dout),  0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rst_s_ovf", 32'(s_ovf), 0);
    check("rst_s_udf", 32'(s_udf), 0);
    check("rst_w_ovf", 32'(w_ovf), 0);
    check("rst_w_udf", 32'(w_udf), 0);
`endif
  endtask

  // One clock of stimulus, issued at a falling edge; the model advances when the stimulus is issued.
  task automatic cyc(input bit w, input bit r, input logic [15:0] d);
    bit ra8, wa8, ra4, wa4;
    wr = w; rd = r; din = d;
    n_vec++;
    ra8 = r && (q8.size() > 0);
    wa8 = w && (q8.size() < 8 || ra8);
    if (w && q8.size() == 8 && !ra8) ovf8 = 1;
    if (r && q8.size() == 0)         udf8 = 1;
    if (ra8) begin
      hold8 = q8.pop_front();
      exp_std.push_back(hold8);
      exp_fw.push_back(hold8);
    end
    if (wa8) q8.push_back(d[7:0]);
    ra4 = r && (q4.size() > 0);
    wa4 = w && (q4.size() < 4 || ra4);
    if (w && q4.size() == 4 && !ra4) ovf4 = 1;
    if (r && q4.size() == 0)         udf4 = 1;
    if (ra4) begin
      hold16 = q4.pop_front();
      exp_w.push_back(hold16);
    end
    if (wa4) q4.push_back(d);
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  // Standard-mode monitors: a read seen at an edge must present its word by the next falling edge.
  bit pend_s = 0, pend_w = 0;
  always @(posedge clk) begin
    pend_s <= !rst && rd && !s_empty;
    pend_w <= !rst && rd && !w_empty;
  end

  always @(negedge clk) begin
    if (pend_s) begin
      if (exp_std.size() == 0) check("std_unexpected_read", 32'(s_dout), 32'hFFFF_FFFF);
      else check("std_data", 32'(s_dout), 32'(exp_std.pop_front()));
    end
    if (pend_w) begin
      if (exp_w.size() == 0) check("w16_unexpected_read", 32'(w_dout), 32'hFFFF_FFFF);
      else check("w16_data", 32'(w_dout), 32'(exp_w.pop_front()));
    end
  end

  // FWFT monitor: the word shown while non-empty is the one consumed by the next read edge.
  logic [7:0] f_seen = '0;
  bit         f_show = 0;
  always @(negedge clk) begin
    f_seen <= f_dout;
    f_show <= !f_empty;
  end

  always @(posedge clk) begin
    if (!rst && rd && f_show) begin
      if (exp_fw.size() == 0) check("fwft_unexpected_read", 32'(f_seen), 32'hFFFF_FFFF);
      else check("fwft_data", 32'(f_seen), 32'(exp_fw.pop_front()));
    end
  end

  initial begin
    int pw;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i * 'h11));
    check("full_after_8", 32'(s_full), 1);
    cyc(1, 0, 16'h0099);
    cyc(1, 1, 16'h00AA);
    check("full_rdwr_cnt", 32'(s_cnt), 8);
    repeat (8) cyc(0, 1, 16'h0);
    check("drained_last_aa", 32'(s_dout), 32'h0000_00AA);
    cyc(1, 1, 16'h005C);
    check("empty_rdwr_cnt", 32'(s_cnt), 1);
    cyc(0, 1, 16'h0);
    cyc(1, 0, 16'h003C);
    check("fwft_first_word", 32'(f_dout), 32'h0000_003C);
    cyc(0, 1, 16'h0);

    for (int i = 0; i < 18; i++) cyc(i % 3 != 2, i % 3 == 2, 16'($urandom));

    for (int i = 0; i < 400; i++) begin
      pw = ((i / 40) % 2 == 0) ? 75 : 25;
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw - 10, 16'($urandom));
    end

    repeat (10) cyc(0, 1, 16'h0);
    repeat (3) cyc(1, 0, 16'($urandom));
    check("w16_cnt_before_rst", 32'(w_cnt), 3);
    #2 rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    #1 check_reset();
    q8.delete(); q4.delete();
    exp_std.delete(); exp_fw.delete(); exp_w.delete();
    hold8 = '0; hold16 = '0;
    ovf8 = 0; udf8 = 0; ovf4 = 0; udf4 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 200; i++) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 16'($urandom));
    repeat (12) cyc(0, 1, 16'h0);
    cyc(0, 0, 16'h0);
    check("scoreboard_left", 32'(exp_std.size() + exp_fw.size() + exp_w.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
